hack_mem_arbiter: RTL and testbench
===================================

Name: hack_mem_arbiter

Overview:
Arbiter that shares the Hack data-memory port (RAM16K/Screen/Keyboard map, 15-bit address, 16-bit data) between the CPU and one DMA requester, such as a screen-fill or keyboard-buffer engine. The CPU has fixed priority. A starvation counter and a bounded DMA burst guarantee DMA progress. The block sits between CPU/DMA and Memory inside Computer. Memory continues to sample mem_in/mem_load/mem_address on its own clock edge.

Parameters:
MAX_WAIT, 4, DMA waiting cycles (saturating) after which DMA pre-empts CPU at the next decision
BURST_LEN, 2, maximum consecutive DMA-granted cycles while dma_req is held (>=1)
CNT_W, 3, width of the starvation and burst counters; must hold MAX_WAIT and BURST_LEN

Ports:
clock  in  1  system clock, rising-edge decisions
reset  in  1  asynchronous, active-high
cpu_req  in  1  CPU requests the memory port
cpu_load  in  1  CPU write enable (1 = write)
cpu_address  in  15  CPU address
cpu_wdata  in  16  CPU write data
cpu_gnt  out  1  CPU owns the port this cycle
cpu_rdata  out  16  read data to the CPU
dma_req  in  1  DMA requests the memory port
dma_load  in  1  DMA write enable
dma_address  in  15  DMA address
dma_wdata  in  16  DMA write data
dma_gnt  out  1  DMA owns the port this cycle
dma_rdata  out  16  read data to the DMA
mem_load  out  1  to Memory load
mem_address  out  15  to Memory address
mem_in  out  16  to Memory in
mem_out  in  16  from Memory out (combinational read)

Behaviour:
- Owner register states: NONE, CPU, DMA. cpu_gnt = (owner==CPU); dma_gnt = (owner==DMA). The two grants are never both 1.
- Reset: owner=NONE, starve_cnt=0, burst_cnt=0. Both grants are 0 and mem_load=0, taking effect immediately (async).
- Bus mux (combinational from owner):
  - owner CPU: mem_address/mem_in from cpu_*; mem_load = cpu_req & cpu_load.
  - owner DMA: same from dma_*.
  - owner NONE: mem_address=0, mem_in=0, mem_load=0.
- Read path: x_rdata = mem_out when x_gnt=1, else 16'h0000. Data is valid in the same cycle as the grant.
- A transfer occurs in every cycle where x_req & x_gnt. A granted cycle with x_req=0 is idle, with mem_load=0.
- Latency: req rises in cycle n → earliest grant in cycle n+1. Grant stays for one cycle after req falls.
- Next-owner decision at each rising edge, first match wins, using pre-edge counter values:
  1. owner==DMA & dma_req & burst_cnt < BURST_LEN-1 → DMA, burst_cnt+1.
  2. dma_req & starve_cnt==MAX_WAIT → DMA, burst_cnt=0.
  3. cpu_req → CPU.
  4. dma_req → DMA, burst_cnt=0.
  5. otherwise → NONE.
- starve_cnt update:
  - +1 (saturating at MAX_WAIT) when dma_req & !dma_gnt.
  - cleared when dma_gnt=1 or dma_req=0.
- burst_cnt is held while owner≠DMA.
- CPU holds the port indefinitely while cpu_req=1 and DMA is idle.
- Both requesting continuously from reset: CPU granted cycles 1-4, DMA 5-6, CPU 7-11, DMA 12-13. Steady state is CPU MAX_WAIT+1 cycles, DMA BURST_LEN cycles.
- Requesters must hold address/data/load stable while req=1 and gnt=0.

Optional Feature:
Macro ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt[15:0]: cycles with cpu_req & dma_req, saturating at 16'hFFFF.
  - Adds output dma_xfer_cnt[15:0]: DMA transfer cycles, wrapping.
  - Both clear on reset and update on rising edges.
- Undefined: neither port nor counter exists; arbitration is identical.

Test Plan:
- Reset: hold reset with cpu_req=dma_req=1 → cpu_gnt=dma_gnt=0, mem_load=0. Release reset → cpu_gnt=1 after the first edge.
- CPU write: cpu_req=1, cpu_load=1, addr=15'h0010, wdata=16'h1234 → next cycle cpu_gnt=1, mem_load=1, mem_address=15'h0010, mem_in=16'h1234.
- DMA read: dma_req=1, dma_load=0, addr=15'h4000, mem_out=16'hBEEF → next cycle dma_gnt=1, dma_rdata=16'hBEEF, cpu_rdata=0, mem_load=0.
- Contention: both req=1 from cycle 0 → grants CPU 1-4, DMA 5-6, CPU 7-11, DMA 12-13. No cycle has both grants.
- Async reset mid-DMA burst (dma_load=1): assert reset between edges → dma_gnt and mem_load fall at once, and no write occurs at the following edge.
- With ARB_STATS_EN: 10 contention cycles plus 3 DMA transfers → conflict_cnt=10, dma_xfer_cnt=3.

Source files
------------

// File: rtl/hack_mem_arbiter_if.sv
// Bundle of CPU, DMA and Memory-side signals around the Hack data-memory arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface hack_mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_load;
  logic [14:0] cpu_address;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic [15:0] cpu_rdata;

  logic        dma_req;
  logic        dma_load;
  logic [14:0] dma_address;
  logic [15:0] dma_wdata;
  logic        dma_gnt;
  logic [15:0] dma_rdata;

  logic        mem_load;
  logic [14:0] mem_address;
  logic [15:0] mem_in;
  logic [15:0] mem_out;

  modport slave (
    input  cpu_req, cpu_load, cpu_address, cpu_wdata,
    input  dma_req, dma_load, dma_address, dma_wdata,
    input  mem_out,
    output cpu_gnt, cpu_rdata, dma_gnt, dma_rdata,
    output mem_load, mem_address, mem_in
  );

  modport master (
    output cpu_req, cpu_load, cpu_address, cpu_wdata,
    output dma_req, dma_load, dma_address, dma_wdata,
    output mem_out,
    input  cpu_gnt, cpu_rdata, dma_gnt, dma_rdata,
    input  mem_load, mem_address, mem_in
  );
endinterface

// File: rtl/hack_mem_arbiter.sv
// CPU-priority arbiter for the Hack data-memory port with DMA starvation guard and bounded burst.
// Optional ARB_STATS_EN adds conflict_cnt / dma_xfer_cnt statistics outputs.
module hack_mem_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_LEN = 2,
  parameter int CNT_W     = 3
) (
  input  logic              clock,
  input  logic              reset,
  hack_mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       dma_xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam logic [CNT_W-1:0] MAX_WAIT_C   = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] BURST_LAST_C = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             cpu_gnt_w, dma_gnt_w;

  assign cpu_gnt_w = (owner_q == OWN_CPU);
  assign dma_gnt_w = (owner_q == OWN_DMA);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      burst_q  <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
    end
  end

  // Ordered decision: burst continuation, starvation pre-emption, CPU priority, plain DMA.
  always_comb begin
    owner_d = OWN_NONE;
    burst_d = burst_q;
    if (dma_gnt_w && bus.dma_req && (burst_q < BURST_LAST_C)) begin
      owner_d = OWN_DMA;
      burst_d = burst_q + ONE_C;
    end else if (bus.dma_req && (starve_q == MAX_WAIT_C)) begin
      owner_d = OWN_DMA;
      burst_d = '0;
    end else if (bus.cpu_req) begin
      owner_d = OWN_CPU;
    end else if (bus.dma_req) begin
      owner_d = OWN_DMA;
      burst_d = '0;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.dma_req || dma_gnt_w) begin
      starve_d = '0;
    end else if (starve_q != MAX_WAIT_C) begin
      starve_d = starve_q + ONE_C;
    end
  end

  always_comb begin
    bus.mem_load    = 1'b0;
    bus.mem_address = '0;
    bus.mem_in      = '0;
    case (owner_q)
      OWN_CPU: begin
        bus.mem_load    = bus.cpu_req & bus.cpu_load;
        bus.mem_address = bus.cpu_address;
        bus.mem_in      = bus.cpu_wdata;
      end
      OWN_DMA: begin
        bus.mem_load    = bus.dma_req & bus.dma_load;
        bus.mem_address = bus.dma_address;
        bus.mem_in      = bus.dma_wdata;
      end
      default: ;
    endcase
  end

  assign bus.cpu_gnt   = cpu_gnt_w;
  assign bus.dma_gnt   = dma_gnt_w;
  assign bus.cpu_rdata = cpu_gnt_w ? bus.mem_out : 16'h0000;
  assign bus.dma_rdata = dma_gnt_w ? bus.mem_out : 16'h0000;

`ifdef ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;
  logic [15:0] xfer_q, xfer_d;

  always_comb begin
    conflict_d = conflict_q;
    xfer_d     = xfer_q;
    if (bus.cpu_req && bus.dma_req && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
    if (bus.dma_req && dma_gnt_w) begin
      xfer_d = xfer_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_q <= '0;
      xfer_q     <= '0;
    end else begin
      conflict_q <= conflict_d;
      xfer_q     <= xfer_d;
    end
  end

  assign conflict_cnt = conflict_q;
  assign dma_xfer_cnt = xfer_q;
`else
  // No statistics state in this build.
`endif

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Self-checking bench for hack_mem_arbiter: grant schedule and write scoreboards plus a memory model.
module tb_hack_mem_arbiter;

  logic clock;
  logic reset;

  hack_mem_arbiter_if arb_if ();

`ifdef ARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [15:0] dma_xfer_cnt;
`endif

  hack_mem_arbiter #(
    .MAX_WAIT  (4),
    .BURST_LEN (2),
    .CNT_W     (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (arb_if)
`ifdef ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .dma_xfer_cnt (dma_xfer_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Memory model: combinational read, write on rising edge; backdoor pokes for preloading.
  logic [15:0] mem [0:32767];
  logic        poke_en;
  logic [14:0] poke_addr;
  logic [15:0] poke_data;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t wr_q[$];

  typedef struct {
    logic cpu;
    logic dma;
  } gnt_t;
  gnt_t gnt_q[$];

  assign arb_if.mem_out = mem[arb_if.mem_address];

  always @(posedge clock) begin
    if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (arb_if.mem_load) begin
      mem[arb_if.mem_address] <= arb_if.mem_in;
      check_eq("wr_expected", 32'(wr_q.size() > 0), 32'd1);
      if (wr_q.size() > 0) begin
        wr_t w;
        w = wr_q.pop_front();
        check_eq("wr_addr", 32'(arb_if.mem_address), 32'(w.addr));
        check_eq("wr_data", 32'(arb_if.mem_in), 32'(w.data));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic poke(input logic [14:0] a, input logic [15:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    tick();
    poke_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    poke_en = 1'b0;
    poke_addr = '0;
    poke_data = '0;
    reset = 1'b1;
    arb_if.cpu_req = 1'b1;
    arb_if.cpu_load = 1'b1;
    arb_if.cpu_address = 15'h0123;
    arb_if.cpu_wdata = 16'h5A5A;
    arb_if.dma_req = 1'b1;
    arb_if.dma_load = 1'b0;
    arb_if.dma_address = 15'h0456;
    arb_if.dma_wdata = 16'hA5A5;

    // Reset held with both requesting
    repeat (2) tick();
    check_eq("rst_cpu_gnt", 32'(arb_if.cpu_gnt), 32'd0);
    check_eq("rst_dma_gnt", 32'(arb_if.dma_gnt), 32'd0);
    check_eq("rst_mem_load", 32'(arb_if.mem_load), 32'd0);
    check_eq("rst_mem_addr", 32'(arb_if.mem_address), 32'd0);

    // Contention from cycle 0: CPU 1-4, DMA 5-6, CPU 7-11, DMA 12-13
    arb_if.cpu_load = 1'b0;
    reset = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      gnt_t e;
      e.dma = (c == 5) || (c == 6) || (c == 12) || (c == 13);
      e.cpu = !e.dma;
      gnt_q.push_back(e);
      tick();
      begin
        gnt_t g;
        g = gnt_q.pop_front();
        check_eq($sformatf("cont_c%0d_cpu", c), 32'(arb_if.cpu_gnt), 32'(g.cpu));
        check_eq($sformatf("cont_c%0d_dma", c), 32'(arb_if.dma_gnt), 32'(g.dma));
        check_eq($sformatf("cont_c%0d_excl", c), 32'(arb_if.cpu_gnt & arb_if.dma_gnt), 32'd0);
      end
    end

    // CPU write
    #1 reset = 1'b1;
    arb_if.dma_req = 1'b0;
    arb_if.cpu_req = 1'b1;
    arb_if.cpu_load = 1'b1;
    arb_if.cpu_address = 15'h0010;
    arb_if.cpu_wdata = 16'h1234;
    #2 reset = 1'b0;
    check_eq("cw_lat_gnt", 32'(arb_if.cpu_gnt), 32'd0);
    wr_q.push_back('{addr: 15'h0010, data: 16'h1234});
    tick();
    check_eq("cw_gnt", 32'(arb_if.cpu_gnt), 32'd1);
    check_eq("cw_mem_load", 32'(arb_if.mem_load), 32'd1);
    check_eq("cw_mem_addr", 32'(arb_if.mem_address), 32'h0010);
    check_eq("cw_mem_in", 32'(arb_if.mem_in), 32'h1234);
    check_eq("cw_dma_gnt", 32'(arb_if.dma_gnt), 32'd0);
    tick();
    arb_if.cpu_req = 1'b0;
    #1;
    check_eq("cw_idle_gnt", 32'(arb_if.cpu_gnt), 32'd1);
    check_eq("cw_idle_load", 32'(arb_if.mem_load), 32'd0);
    check_eq("cw_mem_word", 32'(mem[15'h0010]), 32'h1234);
    tick();
    check_eq("cw_release", 32'(arb_if.cpu_gnt), 32'd0);
    arb_if.cpu_load = 1'b0;

    // DMA read
    poke(15'h4000, 16'hBEEF);
    poke(15'h0100, 16'h5555);
    arb_if.dma_req = 1'b1;
    arb_if.dma_load = 1'b0;
    arb_if.dma_address = 15'h4000;
    #1;
    check_eq("dr_lat_gnt", 32'(arb_if.dma_gnt), 32'd0);
    tick();
    check_eq("dr_gnt", 32'(arb_if.dma_gnt), 32'd1);
    check_eq("dr_rdata", 32'(arb_if.dma_rdata), 32'hBEEF);
    check_eq("dr_cpu_rdata", 32'(arb_if.cpu_rdata), 32'h0000);
    check_eq("dr_mem_load", 32'(arb_if.mem_load), 32'd0);
    arb_if.dma_req = 1'b0;
    tick();
    check_eq("dr_release", 32'(arb_if.dma_gnt), 32'd0);
    check_eq("dr_rdata_idle", 32'(arb_if.dma_rdata), 32'h0000);

    // Async reset during a granted DMA write: no write may reach memory
    arb_if.dma_req = 1'b1;
    arb_if.dma_load = 1'b1;
    arb_if.dma_address = 15'h0100;
    arb_if.dma_wdata = 16'hAAAA;
    tick();
    check_eq("ar_gnt", 32'(arb_if.dma_gnt), 32'd1);
    check_eq("ar_mem_load", 32'(arb_if.mem_load), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("ar_gnt_drop", 32'(arb_if.dma_gnt), 32'd0);
    check_eq("ar_load_drop", 32'(arb_if.mem_load), 32'd0);
    tick();
    check_eq("ar_no_write", 32'(mem[15'h0100]), 32'h5555);
    arb_if.dma_load = 1'b0;

`ifdef ARB_STATS_EN
    check_eq("st_rst_conflict", 32'(conflict_cnt), 32'd0);
    check_eq("st_rst_xfer", 32'(dma_xfer_cnt), 32'd0);
    arb_if.cpu_req = 1'b1;
    arb_if.dma_req = 1'b1;
    reset = 1'b0;
    repeat (10) tick();
    arb_if.cpu_req = 1'b0;
    repeat (2) tick();
    arb_if.dma_req = 1'b0;
    tick();
    check_eq("st_conflict", 32'(conflict_cnt), 32'd10);
    check_eq("st_xfer", 32'(dma_xfer_cnt), 32'd3);
`endif

    check_eq("wr_drained", 32'(wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
